// File: rtl/booth_prod_accum.sv
// Frame accumulator behind the Booth multiplier: sums N signed products with saturation
// and hands each frame sum downstream over a valid/ready handshake.
module booth_prod_accum #(
  parameter int unsigned PW = 8,
  parameter int unsigned AW = 16,
  parameter int unsigned N  = 4,
  localparam int unsigned CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic [PW-1:0] prod,
  input  logic          prod_valid,
  output logic          prod_ready,
  output logic [AW-1:0] sum,
  output logic          sum_valid,
  input  logic          sum_ready,
  output logic          ovf,
  output logic [CW-1:0] cnt
);

  typedef enum logic {StAcc, StDone} state_e;

  state_e        state_q;
  logic [AW-1:0] acc_q;
  logic [CW-1:0] cnt_q;
  logic          ovf_q;
  logic          sum_valid_q;

  logic [AW:0]   sum_wide;
  logic [AW-1:0] acc_sat;
  logic          sat_hit;
  logic [CW-1:0] cnt_inc;
  logic          last;
  logic          accept;

  // One guard bit above AW is enough to detect overflow of a single add.
  assign sum_wide = {acc_q[AW-1], acc_q} + {{(AW + 1 - PW){prod[PW-1]}}, prod};

  always_comb begin
    acc_sat = sum_wide[AW-1:0];
    sat_hit = 1'b0;
    if (sum_wide[AW] != sum_wide[AW-1]) begin
      sat_hit = 1'b1;
      acc_sat = sum_wide[AW] ? {1'b1, {(AW - 1){1'b0}}} : {1'b0, {(AW - 1){1'b1}}};
    end
  end

  assign prod_ready = (state_q == StAcc) && !clr;
  assign accept     = prod_valid && prod_ready;
  assign cnt_inc    = cnt_q + 1'b1;
  assign last       = (cnt_inc == CW'(N));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state_q     <= StAcc;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      sum_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StAcc: begin
          if (accept) begin
            acc_q <= acc_sat;
            ovf_q <= ovf_q | sat_hit;
            cnt_q <= cnt_inc;
            if (last) begin
              state_q     <= StDone;
              sum_valid_q <= 1'b1;
            end
          end
        end
        StDone: begin
          if (sum_ready) begin
            state_q     <= StAcc;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            sum_valid_q <= 1'b0;
          end
        end
        default: state_q <= StAcc;
      endcase
    end
  end

  // acc_q is frozen in StDone, so it doubles as the stable frame sum.
  assign sum       = acc_q;
  assign sum_valid = sum_valid_q;
  assign ovf       = ovf_q;
  assign cnt       = cnt_q;

endmodule

// File: tb/tb_booth_prod_accum.sv
// Drives a 16-bit and an 8-bit accumulator in lockstep and checks both against
// an integer frame model with clamped addition.
module tb_booth_prod_accum;

  localparam int NP = 4;

  logic       clk = 1'b0;
  logic       rst, clr, prod_valid, sum_ready;
  logic [7:0] prod;

  logic        prod_ready_a, sum_valid_a, ovf_a;
  logic [15:0] sum_a;
  logic [2:0]  cnt_a;
  logic        prod_ready_b, sum_valid_b, ovf_b;
  logic [7:0]  sum_b;
  logic [2:0]  cnt_b;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: frame position, and per-instance sum and overflow flag.
  bit m_done;
  int m_cnt;
  int m_acc [2];
  bit m_ovf [2];
  int hi [2] = '{32767, 127};
  int lo [2] = '{-32768, -128};

  always #5 clk = ~clk;

  booth_prod_accum #(.PW(8), .AW(16), .N(NP)) dut_a (
    .clk(clk), .rst(rst), .clr(clr), .prod(prod), .prod_valid(prod_valid),
    .prod_ready(prod_ready_a), .sum(sum_a), .sum_valid(sum_valid_a),
    .sum_ready(sum_ready), .ovf(ovf_a), .cnt(cnt_a)
  );

  booth_prod_accum #(.PW(8), .AW(8), .N(NP)) dut_b (
    .clk(clk), .rst(rst), .clr(clr), .prod(prod), .prod_valid(prod_valid),
    .prod_ready(prod_ready_b), .sum(sum_b), .sum_valid(sum_valid_b),
    .sum_ready(sum_ready), .ovf(ovf_b), .cnt(cnt_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_done = 1'b0;
    m_cnt  = 0;
    for (int k = 0; k < 2; k++) begin
      m_acc[k] = 0;
      m_ovf[k] = 1'b0;
    end
  endtask

  task automatic model_step(input bit r, input bit c, input bit v, input logic [7:0] p,
                            input bit s);
    int pv;
    int t;
    pv = int'($signed(p));
    if (r || c) begin
      model_clear();
    end else if (!m_done) begin
      if (v) begin
        for (int k = 0; k < 2; k++) begin
          t = m_acc[k] + pv;
          if (t > hi[k]) begin
            t = hi[k];
            m_ovf[k] = 1'b1;
          end else if (t < lo[k]) begin
            t = lo[k];
            m_ovf[k] = 1'b1;
          end
          m_acc[k] = t;
        end
        m_cnt++;
        if (m_cnt == NP) m_done = 1'b1;
      end
    end else if (s) begin
      model_clear();
    end
  endtask

  task automatic cycle(input bit r, input bit c, input bit v, input logic [7:0] p, input bit s);
    logic [15:0] ea;
    logic [7:0]  eb;
    rst = r; clr = c; prod_valid = v; prod = p; sum_ready = s;
    #1;
    check_eq("prod_ready_a", {31'd0, prod_ready_a}, {31'd0, !m_done && !c});
    check_eq("prod_ready_b", {31'd0, prod_ready_b}, {31'd0, !m_done && !c});
    @(posedge clk);
    model_step(r, c, v, p, s);
    @(negedge clk);
    ea = m_acc[0][15:0];
    eb = m_acc[1][7:0];
    check_eq("sum_valid_a", {31'd0, sum_valid_a}, {31'd0, m_done});
    check_eq("sum_valid_b", {31'd0, sum_valid_b}, {31'd0, m_done});
    check_eq("cnt_a", {29'd0, cnt_a}, 32'(m_cnt));
    check_eq("cnt_b", {29'd0, cnt_b}, 32'(m_cnt));
    check_eq("ovf_a", {31'd0, ovf_a}, {31'd0, m_ovf[0]});
    check_eq("ovf_b", {31'd0, ovf_b}, {31'd0, m_ovf[1]});
    if (m_done) begin
      check_eq("sum_a", {16'd0, sum_a}, {16'd0, ea});
      check_eq("sum_b", {24'd0, sum_b}, {24'd0, eb});
    end
  endtask

  initial begin
    logic [7:0] basic [4];
    int vpat [7];
    logic [7:0] satp [4];
    logic [7:0] rp;
    basic = '{8'hEE, 8'hD6, 8'h07, 8'h1E};
    vpat  = '{1, 0, 0, 1, 0, 1, 1};
    satp  = '{8'h7F, 8'h7F, 8'h80, 8'h00};

    rst = 1'b1; clr = 1'b0; prod_valid = 1'b0; prod = 8'h00; sum_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_clear();
    cycle(1, 0, 0, 8'h00, 0);
    check_eq("reset_sum_a", {16'd0, sum_a}, 32'd0);

    // Basic frame; sum_valid must appear the cycle after the 4th accept.
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, basic[i], 0);
    check_eq("basic_sum", {16'd0, sum_a}, 32'h0000FFE9);
    check_eq("basic_valid", {31'd0, sum_valid_a}, 32'd1);

    // Backpressure while DONE, then release and accept 0x10 right after.
    for (int i = 0; i < 5; i++) cycle(0, 0, 1, 8'h10, 0);
    check_eq("bp_sum_stable", {16'd0, sum_a}, 32'h0000FFE9);
    cycle(0, 0, 1, 8'h10, 1);
    cycle(0, 0, 1, 8'h10, 0);
    check_eq("bp_accept_cnt", {29'd0, cnt_a}, 32'd1);
    cycle(0, 1, 0, 8'h00, 0);

    // Gapped valid.
    for (int i = 0; i < 7; i++) cycle(0, 0, vpat[i] != 0, 8'h01, 0);
    check_eq("gap_sum", {16'd0, sum_a}, 32'h00000004);
    cycle(0, 0, 0, 8'h00, 1);

    // Saturation on the 8-bit instance, both rails.
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, satp[i], 0);
    check_eq("sat_pos_sum_b", {24'd0, sum_b}, 32'h000000FF);
    check_eq("sat_pos_ovf_b", {31'd0, ovf_b}, 32'd1);
    cycle(0, 0, 0, 8'h00, 1);
    cycle(0, 0, 1, 8'h80, 0);
    cycle(0, 0, 1, 8'h80, 0);
    check_eq("sat_neg_ovf_b", {31'd0, ovf_b}, 32'd1);
    cycle(0, 0, 1, 8'h00, 0);
    cycle(0, 0, 1, 8'h00, 0);
    check_eq("sat_neg_sum_b", {24'd0, sum_b}, 32'h00000080);
    cycle(0, 0, 0, 8'h00, 1);

    // clr mid-frame drops the product presented alongside it.
    cycle(0, 0, 1, 8'h05, 0);
    cycle(0, 0, 1, 8'h05, 0);
    cycle(0, 1, 1, 8'h09, 0);
    check_eq("clr_cnt", {29'd0, cnt_a}, 32'd0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, 8'h01, 0);
    check_eq("clr_sum", {16'd0, sum_a}, 32'h00000004);

    // Reset while a sum is pending.
    cycle(1, 0, 0, 8'h00, 0);
    check_eq("rst_done_valid", {31'd0, sum_valid_a}, 32'd0);
    check_eq("rst_done_sum", {16'd0, sum_a}, 32'd0);

    // Random traffic, biased toward the rails so the 8-bit instance saturates often.
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0:       rp = 8'h7F;
        1:       rp = 8'h80;
        default: rp = 8'($urandom);
      endcase
      cycle($urandom_range(0, 199) == 0, $urandom_range(0, 39) == 0,
            $urandom_range(0, 3) != 0, rp, $urandom_range(0, 2) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
